// File: rtl/field_pkg.sv
// Shared field definitions for the EC field processor.
// The default modulus is the Mersenne prime 2^107 - 1. It is odd and below
// 2^110, so R = 2^110 works as the Montgomery radix.
package field_pkg;

    localparam int R_BITS = 110;

    localparam logic [R_BITS-1:0] MODULUS = {3'b000, {107{1'b1}}};

    // R^2 mod M = 2^220 mod (2^107 - 1) = 2^6. Used to map values into the
    // Montgomery domain: mont(x, R2_MOD_M) = x*R mod M.
    localparam logic [R_BITS-1:0] R2_MOD_M = R_BITS'(64);

    typedef enum logic [1:0] {
        ST_IDLE_LOAD,
        ST_ITER,
        ST_FINAL,
        ST_DONE
    } mont_state_e;

endpackage

// File: rtl/mont_mul_step.sv
// One radix-2 Montgomery iteration, purely combinational:
//   o_s = (i_s + a_bit*B + q*M) / 2, where q is the parity of (i_s + a_bit*B).
// With i_s < 2M and B < M, the intermediate sum stays below 4M and fits in
// WIDTH+2 bits, and o_s stays below 2M.
module mont_mul_step #(
    parameter int WIDTH = field_pkg::R_BITS,
    parameter logic [WIDTH-1:0] MODULUS = field_pkg::MODULUS
) (
    input  logic [WIDTH+1:0] i_s,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_a_bit,
    output logic [WIDTH+1:0] o_s
);

    logic [WIDTH+1:0] w_t;
    logic [WIDTH+1:0] w_u;

    // Add the selected multiplicand, then add M when needed so the sum is even.
    always_comb begin
        w_t = i_s + (i_a_bit ? {2'b00, i_b} : '0);
        w_u = w_t + (w_t[0] ? {2'b00, MODULUS} : '0);
        o_s = w_u >> 1;
    end

endmodule

// File: rtl/mont_mul_p.sv
// Bit-serial Montgomery multiplier: o_r = a*b*R^-1 mod MODULUS, R = 2^WIDTH.
// This is a one-shot unit. Releasing i_rst_n starts one multiplication, and
// o_done then stays high until the next reset.
// Optional build macro MONT_MUL_UNROLL2_EN: chain two step instances so that
// each clock does two iterations. This needs an even WIDTH and gives a latency
// of WIDTH/2+2 edges instead of WIDTH+2.
//
// state        | meaning
// ST_IDLE_LOAD | sample a/b, clear accumulator and counter
// ST_ITER      | one (or two) Montgomery iterations per clock
// ST_FINAL     | conditional subtract, register result, raise done
// ST_DONE      | hold result until reset
module mont_mul_p #(
    parameter int WIDTH = field_pkg::R_BITS,
    parameter logic [WIDTH-1:0] MODULUS = field_pkg::MODULUS
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_r,
    output logic             o_done
);
    import field_pkg::*;

`ifdef MONT_MUL_UNROLL2_EN
    localparam int STEPS = 2;
    if (WIDTH % 2 != 0) begin : g_width_check
        $error("mont_mul_p: WIDTH must be even with two iterations per clock");
    end
`else
    localparam int STEPS = 1;
`endif

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - STEPS);
    localparam logic [CW-1:0] CNT_INC  = CW'(STEPS);

    mont_state_e      r_state;
    mont_state_e      w_next_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH+1:0] r_s;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_res;
    logic             r_done;
    logic [WIDTH+1:0] w_s_next;
    logic [WIDTH-1:0] w_s_red;
    logic [WIDTH-1:0] w_final;

`ifdef MONT_MUL_UNROLL2_EN
    logic [WIDTH+1:0] w_s_mid;

    mont_mul_step #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_step0 (
        .i_s     (r_s),
        .i_b     (r_b),
        .i_a_bit (r_a[0]),
        .o_s     (w_s_mid)
    );

    mont_mul_step #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_step1 (
        .i_s     (w_s_mid),
        .i_b     (r_b),
        .i_a_bit (r_a[1]),
        .o_s     (w_s_next)
    );
`else
    mont_mul_step #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_step0 (
        .i_s     (r_s),
        .i_b     (r_b),
        .i_a_bit (r_a[0]),
        .o_s     (w_s_next)
    );
`endif

    // The accumulator ends below 2M, so a single subtract reduces it into [0, M).
    // The difference is only used when S >= M, where it fits in WIDTH bits.
    always_comb begin
        w_s_red = r_s[WIDTH-1:0] - MODULUS;
        w_final = (r_s >= {2'b00, MODULUS}) ? w_s_red : r_s[WIDTH-1:0];
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE_LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic. Load, then iterate until the last count, finalize, hold.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE_LOAD: w_next_state = ST_ITER;
            ST_ITER:      if (r_cnt == CNT_LAST) w_next_state = ST_FINAL;
            ST_FINAL:     w_next_state = ST_DONE;
            ST_DONE:      w_next_state = ST_DONE;
            default:      w_next_state = ST_IDLE_LOAD;
        endcase
    end

    // Datapath. Operands are sampled only in the load state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_s    <= '0;
            r_cnt  <= '0;
            r_res  <= '0;
            r_done <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE_LOAD: begin
                    r_a   <= i_a;
                    r_b   <= i_b;
                    r_s   <= '0;
                    r_cnt <= '0;
                end
                ST_ITER: begin
                    r_s   <= w_s_next;
                    r_a   <= r_a >> STEPS;
                    r_cnt <= r_cnt + CNT_INC;
                end
                ST_FINAL: begin
                    r_res  <= w_final;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_r    = r_res;
    assign o_done = r_done;

endmodule

// File: tb/tb_mont_mul_p.sv
// Directed bench for mont_mul_p. The small instance uses WIDTH=8 and M=251
// (R mod M = 5, R^-1 mod M = 201). The full instance uses the package modulus
// 2^107-1 with R = 2^110, so R^-1 mod M = 2^104.
module tb_mont_mul_p;

`ifdef MONT_MUL_UNROLL2_EN
    localparam int LAT8   = 6;
    localparam int LAT110 = 57;
`else
    localparam int LAT8   = 10;
    localparam int LAT110 = 112;
`endif
    localparam int NRAND = 300;

    logic         clk;
    logic         rst_n8;
    logic [7:0]   a8, b8, r8;
    logic         done8;
    logic         rst_n110;
    logic [109:0] a110, b110, r110;
    logic         done110;

    int n_checks = 0;
    int n_fail   = 0;

    mont_mul_p #(.WIDTH(8), .MODULUS(8'd251)) u_dut8 (
        .i_clk   (clk),
        .i_rst_n (rst_n8),
        .i_a     (a8),
        .i_b     (b8),
        .o_r     (r8),
        .o_done  (done8)
    );

    mont_mul_p u_dut110 (
        .i_clk   (clk),
        .i_rst_n (rst_n110),
        .i_a     (a110),
        .i_b     (b110),
        .o_r     (r110),
        .o_done  (done110)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: (x*y mod M) * 2^104 mod M, which equals x*y*R^-1 mod M.
    function automatic logic [109:0] gold(input logic [109:0] x, input logic [109:0] y);
        logic [255:0] m;
        logic [255:0] p;
        m = {146'd0, field_pkg::MODULUS};
        p = {146'd0, x} * {146'd0, y};
        p = p % m;
        p = (p << 104) % m;
        return p[109:0];
    endfunction

    task automatic start8(input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        rst_n8 = 1'b0;
        a8 = x;
        b8 = y;
        @(negedge clk);
        rst_n8 = 1'b1;
    endtask

    task automatic wait_done8(output int lat);
        lat = -1;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (done8 === 1'b1) begin
                lat = e;
                break;
            end
        end
    endtask

    task automatic run8(input string name, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] exp_r);
        int lat;
        start8(x, y);
        wait_done8(lat);
        n_checks++;
        if (lat !== LAT8) begin
            n_fail++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, LAT8);
        end
        n_checks++;
        if (r8 !== exp_r) begin
            n_fail++;
            $display("FAIL %s result: got %0d expected %0d", name, r8, exp_r);
        end
    endtask

    task automatic run110(input string name, input logic [109:0] x, input logic [109:0] y,
                          input logic [109:0] exp_r);
        int lat;
        @(negedge clk);
        rst_n110 = 1'b0;
        a110 = x;
        b110 = y;
        @(negedge clk);
        rst_n110 = 1'b1;
        lat = -1;
        for (int e = 1; e <= 200; e++) begin
            @(posedge clk);
            #1;
            if (done110 === 1'b1) begin
                lat = e;
                break;
            end
        end
        n_checks++;
        if (lat !== LAT110) begin
            n_fail++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, LAT110);
        end
        n_checks++;
        if (r110 !== exp_r) begin
            n_fail++;
            $display("FAIL %s result: got %h expected %h (a=%h b=%h)", name, r110, exp_r, x, y);
        end
    endtask

    task automatic test_reset;
        rst_n8 = 1'b0;
        rst_n110 = 1'b0;
        a8 = 8'd77;
        b8 = 8'd99;
        a110 = '0;
        b110 = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (done8 !== 1'b0 || r8 !== 8'd0) begin
            n_fail++;
            $display("FAIL reset8: got done=%0d r=%0d expected done=0 r=0", done8, r8);
        end
        n_checks++;
        if (done110 !== 1'b0 || r110 !== 110'd0) begin
            n_fail++;
            $display("FAIL reset110: got done=%0d r=%h expected done=0 r=0", done110, r110);
        end
    endtask

    task automatic test_identity;
        run8("identity", 8'd5, 8'd77, 8'd77);
    endtask

    task automatic test_zero_unity;
        run8("zero_a", 8'd0, 8'd123, 8'd0);
        run8("zero_b", 8'd45, 8'd0, 8'd0);
        run8("unity", 8'd1, 8'd1, 8'd201);
    endtask

    task automatic test_max;
        run8("max", 8'd250, 8'd250, 8'd201);
        // 2*3*201 mod 251 = 1206 - 1004 = 202
        run8("small", 8'd2, 8'd3, 8'd202);
    endtask

    task automatic test_hold;
        int lat;
        start8(8'd5, 8'd77);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        a8 = 8'd250;
        b8 = 8'd3;
        wait_done8(lat);
        n_checks++;
        if (lat < 0 || lat + 3 !== LAT8) begin
            n_fail++;
            $display("FAIL sample latency: got %0d expected %0d", lat < 0 ? lat : lat + 3, LAT8);
        end
        n_checks++;
        if (r8 !== 8'd77) begin
            n_fail++;
            $display("FAIL sample result: got %0d expected 77", r8);
        end
        a8 = 8'd17;
        b8 = 8'd99;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (r8 !== 8'd77 || done8 !== 1'b1) begin
                n_fail++;
                $display("FAIL hold cycle %0d: got r=%0d done=%0d expected r=77 done=1", i, r8, done8);
            end
        end
        // Asynchronous reset while done is high clears outputs before any edge.
        #2;
        rst_n8 = 1'b0;
        #1;
        n_checks++;
        if (done8 !== 1'b0 || r8 !== 8'd0) begin
            n_fail++;
            $display("FAIL async_clear_done: got done=%0d r=%0d expected done=0 r=0", done8, r8);
        end
    endtask

    task automatic test_reset_mid;
        start8(8'd250, 8'd250);
        repeat (4) @(posedge clk);
        #2;
        rst_n8 = 1'b0;
        #1;
        n_checks++;
        if (done8 !== 1'b0 || r8 !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got done=%0d r=%0d expected done=0 r=0", done8, r8);
        end
        run8("after_reset_mid", 8'd5, 8'd200, 8'd200);
    endtask

    task automatic test_full_width;
        logic [109:0] m;
        logic [127:0] w;
        logic [109:0] x;
        logic [109:0] y;
        m = field_pkg::MODULUS;
        // mont(1, R^2) = R mod M = 2^110 mod (2^107-1) = 8
        run110("w110_r2", 110'd1, field_pkg::R2_MOD_M, 110'd8);
        // mont(1, 1) = R^-1 = 2^104
        run110("w110_unity", 110'd1, 110'd1, 110'd1 << 104);
        run110("w110_zero", 110'd0, m - 110'd1, 110'd0);
        // (M-1)^2 = 1 mod M, so the result is R^-1 = 2^104
        run110("w110_max", m - 110'd1, m - 110'd1, 110'd1 << 104);
        for (int i = 0; i < NRAND; i++) begin
            w = {$urandom, $urandom, $urandom, $urandom};
            x = {3'b000, w[106:0]};
            if (x == m) x = '0;
            w = {$urandom, $urandom, $urandom, $urandom};
            y = {3'b000, w[106:0]};
            if (y == m) y = '0;
            run110("w110_rand", x, y, gold(x, y));
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_zero_unity();
        test_max();
        test_hold();
        test_reset_mid();
        test_full_width();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
